// File: rtl/cbus_arbiter_n_if.sv
// Bundles the per-channel request/response ports, the memory-side cbus and the
// grant status of cbus_arbiter_n. `slave` is the arbiter's view, `master` the environment's.
interface cbus_arbiter_n_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
);
    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int STRB_W = DATA_W / 8;

    // channel side
    logic [NUM_CH-1:0]              ireq_valid;
    logic [NUM_CH-1:0]              ireq_is_write;
    logic [NUM_CH-1:0][2:0]         ireq_size;
    logic [NUM_CH-1:0][ADDR_W-1:0]  ireq_addr;
    logic [NUM_CH-1:0][STRB_W-1:0]  ireq_strobe;
    logic [NUM_CH-1:0][DATA_W-1:0]  ireq_data;
    logic [NUM_CH-1:0][LEN_W-1:0]   ireq_len;
    logic [NUM_CH-1:0][1:0]         ireq_burst;
    logic [NUM_CH-1:0]              iresp_ready;
    logic [NUM_CH-1:0]              iresp_last;
    logic [NUM_CH-1:0][DATA_W-1:0]  iresp_data;

    // memory side
    logic                           oreq_valid;
    logic                           oreq_is_write;
    logic [2:0]                     oreq_size;
    logic [ADDR_W-1:0]              oreq_addr;
    logic [STRB_W-1:0]              oreq_strobe;
    logic [DATA_W-1:0]              oreq_data;
    logic [LEN_W-1:0]               oreq_len;
    logic [1:0]                     oreq_burst;
    logic                           oresp_ready;
    logic                           oresp_last;
    logic [DATA_W-1:0]              oresp_data;

    logic                           grant_valid;
    logic [IDX_W-1:0]               grant_idx;

    modport slave (
        input  ireq_valid, ireq_is_write, ireq_size, ireq_addr, ireq_strobe,
               ireq_data, ireq_len, ireq_burst,
        output iresp_ready, iresp_last, iresp_data,
        output oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe,
               oreq_data, oreq_len, oreq_burst,
        input  oresp_ready, oresp_last, oresp_data,
        output grant_valid, grant_idx
    );

    modport master (
        output ireq_valid, ireq_is_write, ireq_size, ireq_addr, ireq_strobe,
               ireq_data, ireq_len, ireq_burst,
        input  iresp_ready, iresp_last, iresp_data,
        input  oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe,
               oreq_data, oreq_len, oreq_burst,
        output oresp_ready, oresp_last, oresp_data,
        input  grant_valid, grant_idx
    );
endinterface

// File: rtl/cbus_arbiter_n.sv
// N-channel cbus arbiter: registered grant held for a whole burst, round-robin by default.
// Define CBUS_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest, no rr pointer).
module cbus_arbiter_n_lane #(
    parameter int DATA_W = 64
) (
    input  logic              sel,
    input  logic              oresp_ready,
    input  logic              oresp_last,
    input  logic [DATA_W-1:0] oresp_data,
    output logic              iresp_ready,
    output logic              iresp_last,
    output logic [DATA_W-1:0] iresp_data
);
    assign iresp_ready = sel & oresp_ready;
    assign iresp_last  = sel & oresp_last;
    assign iresp_data  = sel ? oresp_data : '0;
endmodule

module cbus_arbiter_n #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    cbus_arbiter_n_if.slave    bus
);
    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             active;
    logic             gnt_req_valid;

`ifndef CBUS_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    assign any_req = |bus.ireq_valid;

`ifdef CBUS_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last to overwrite.
    always_comb begin
        winner = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (bus.ireq_valid[k]) winner = IDX_W'(k);
        end
    end
`else
    // Scan offsets high-to-low from rr_ptr so the nearest valid channel wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = rr_ptr_q;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (bus.ireq_valid[IDX_W'(idx)]) winner = IDX_W'(idx);
        end
    end
`endif

    assign gnt_req_valid = bus.ireq_valid[grant_idx_q];

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
`ifndef CBUS_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = BUSY;
                    grant_idx_d = winner;
`ifndef CBUS_ARB_FIXED_PRIO_EN
                    rr_ptr_d    = (winner == IDX_W'(NUM_CH - 1)) ? '0 : winner + IDX_W'(1);
`endif
                end
            end
            BUSY: begin
                // A requester dropping valid mid-burst ends the grant like a last beat.
                if (!gnt_req_valid || (bus.oresp_ready && bus.oresp_last))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
`ifndef CBUS_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Routing is gated by reset too, so an aborted burst sees nothing the same cycle.
    assign active          = reset && (state_q == BUSY);
    assign bus.grant_valid = (state_q == BUSY);
    assign bus.grant_idx   = grant_idx_q;

    assign bus.oreq_valid    = active && gnt_req_valid;
    assign bus.oreq_is_write = active && bus.ireq_is_write[grant_idx_q];
    assign bus.oreq_size     = active ? bus.ireq_size[grant_idx_q]   : 3'd0;
    assign bus.oreq_addr     = active ? bus.ireq_addr[grant_idx_q]   : '0;
    assign bus.oreq_strobe   = active ? bus.ireq_strobe[grant_idx_q] : '0;
    assign bus.oreq_data     = active ? bus.ireq_data[grant_idx_q]   : '0;
    assign bus.oreq_len      = active ? bus.ireq_len[grant_idx_q]    : '0;
    assign bus.oreq_burst    = active ? bus.ireq_burst[grant_idx_q]  : 2'd0;

    logic [NUM_CH-1:0]             lane_ready;
    logic [NUM_CH-1:0]             lane_last;
    logic [NUM_CH-1:0][DATA_W-1:0] lane_data;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        cbus_arbiter_n_lane #(.DATA_W(DATA_W)) u_lane (
            .sel         (active && (grant_idx_q == IDX_W'(g))),
            .oresp_ready (bus.oresp_ready),
            .oresp_last  (bus.oresp_last),
            .oresp_data  (bus.oresp_data),
            .iresp_ready (lane_ready[g]),
            .iresp_last  (lane_last[g]),
            .iresp_data  (lane_data[g])
        );
    end

    assign bus.iresp_ready = lane_ready;
    assign bus.iresp_last  = lane_last;
    assign bus.iresp_data  = lane_data;

    logic unused_strb;
    assign unused_strb = (STRB_W == 0);
endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Randomized bench for cbus_arbiter_n against a transaction-level grant model.
module tb_cbus_arbiter_n;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_arbiter_n_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    cbus_arbiter_n #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: owner channel (-1 = none), last granted index, next-priority pointer, beat count
    int m_owner = -1;
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_beat  = 0;
    int rst_hold = 0;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef CBUS_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic new_req(input int c, input int max_len);
        bus.ireq_valid[c]    = 1'b1;
        bus.ireq_is_write[c] = 1'($urandom_range(0, 1));
        bus.ireq_size[c]     = 3'($urandom_range(0, 3));
        bus.ireq_addr[c]     = {$urandom(), $urandom()};
        bus.ireq_strobe[c]   = 8'($urandom());
        bus.ireq_data[c]     = {$urandom(), $urandom()};
        bus.ireq_len[c]      = LW'($urandom_range(0, max_len));
        bus.ireq_burst[c]    = 2'($urandom_range(0, 2));
    endtask

    // Advance the model over the clock edge; returns the channel whose burst just completed.
    task automatic model_step(output int fin);
        int w;
        fin = -1;
        if (!reset) begin
            m_owner = -1;
            m_idx   = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            w = pick(bus.ireq_valid, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_idx   = w;
                m_ptr   = (w + 1) % N;
                m_beat  = 0;
            end
        end else begin
            if (bus.oresp_ready) m_beat++;
            if (bus.oresp_ready && bus.oresp_last) fin = m_owner;
            if (!bus.ireq_valid[m_owner] || (bus.oresp_ready && bus.oresp_last)) m_owner = -1;
        end
    endtask

    task automatic check_outputs();
        logic             act;
        logic [N-1:0]     exp_rdy;
        logic [N-1:0]     exp_last;
        act      = reset && (m_owner >= 0);
        exp_rdy  = '0;
        exp_last = '0;
        if (act) begin
            exp_rdy[m_owner]  = bus.oresp_ready;
            exp_last[m_owner] = bus.oresp_last;
        end
        chk("grant_valid", 64'(bus.grant_valid), 64'(m_owner >= 0));
        chk("grant_idx", 64'(bus.grant_idx), 64'(m_idx));
        chk("oreq_valid", 64'(bus.oreq_valid), 64'(act && bus.ireq_valid[m_owner < 0 ? 0 : m_owner]));
        chk("iresp_ready", 64'(bus.iresp_ready), 64'(exp_rdy));
        chk("iresp_last", 64'(bus.iresp_last), 64'(exp_last));
        if (act) begin
            chk("oreq_addr", bus.oreq_addr, bus.ireq_addr[m_owner]);
            chk("oreq_data", bus.oreq_data, bus.ireq_data[m_owner]);
            chk("oreq_ctl", {40'd0, bus.oreq_is_write, bus.oreq_size, bus.oreq_strobe, bus.oreq_len, bus.oreq_burst},
                {40'd0, bus.ireq_is_write[m_owner], bus.ireq_size[m_owner], bus.ireq_strobe[m_owner],
                 bus.ireq_len[m_owner], bus.ireq_burst[m_owner]});
        end else begin
            chk("oreq_addr_idle", bus.oreq_addr, 64'd0);
        end
        for (int c = 0; c < N; c++)
            chk($sformatf("iresp_data%0d", c), bus.iresp_data[c],
                (act && c == m_owner) ? bus.oresp_data : 64'd0);
    endtask

    // Directed cycle: every channel keeps a single-beat request, memory completes every beat.
    task automatic cycle_directed();
        int fin;
        @(posedge clk);
        model_step(fin);
        #1;
        if (fin >= 0) new_req(fin, 0);
        bus.oresp_ready = 1'b1;
        bus.oresp_last  = 1'b1;
        bus.oresp_data  = {$urandom(), $urandom()};
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cycle_random();
        int fin;
        @(posedge clk);
        model_step(fin);
        #1;
        if (fin >= 0) bus.ireq_valid[fin] = 1'b0;
        for (int c = 0; c < N; c++)
            if (!bus.ireq_valid[c] && $urandom_range(0, 3) == 0) new_req(c, 5);
        // occasional protocol violation: the granted channel walks away mid-burst
        if (m_owner >= 0 && $urandom_range(0, 49) == 0) bus.ireq_valid[m_owner] = 1'b0;
        if (rst_hold > 0) begin
            rst_hold--;
        end else if ($urandom_range(0, 249) == 0) begin
            reset    = 1'b0;
            rst_hold = $urandom_range(0, 2);
        end else begin
            reset = 1'b1;
        end
        if (m_owner >= 0) begin
            bus.oresp_ready = ($urandom_range(0, 9) < 7);
            bus.oresp_last  = bus.oresp_ready && (m_beat == int'(bus.ireq_len[m_owner]));
        end else begin
            bus.oresp_ready = 1'($urandom_range(0, 1));
            bus.oresp_last  = 1'($urandom_range(0, 1));
        end
        bus.oresp_data = {$urandom(), $urandom()};
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        reset = 1'b0;
        bus.ireq_valid  = '0;
        bus.oresp_ready = 1'b0;
        bus.oresp_last  = 1'b0;
        bus.oresp_data  = '0;
        for (int c = 0; c < N; c++) new_req(c, 0);
        for (int i = 0; i < 3; i++) cycle_directed();
        reset = 1'b1;
        for (int i = 0; i < 24; i++) cycle_directed();
        for (int i = 0; i < 4000; i++) cycle_random();
        $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cbus_arbiter_n.md
Name: cbus_arbiter_n

Overview:
- N-channel cache-bus arbiter between the core's bus converters (instruction, data, and future DMA/uncached ports) and the single memory-side cbus.
- Grants one requester at a time and holds the grant for the whole burst.
- Round-robin fairness by default.
- Registered grant with an explicit lock state, replacing the fixed two-input muxing used today.

Parameters:
NUM_CH, 4, number of requesting channels (>=2)
ADDR_W, 64, address width
DATA_W, 64, data width (multiple of 8)
LEN_W, 8, burst-length field width (len = beats-1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
ireq_valid  input  NUM_CH  per-channel request valid
ireq_is_write  input  NUM_CH  per-channel write flag
ireq_size  input  NUM_CH*3  per-channel transfer size
ireq_addr  input  NUM_CH*ADDR_W  per-channel address
ireq_strobe  input  NUM_CH*DATA_W/8  per-channel byte strobe
ireq_data  input  NUM_CH*DATA_W  per-channel write data
ireq_len  input  NUM_CH*LEN_W  per-channel beats-1
ireq_burst  input  NUM_CH*2  per-channel burst type
iresp_ready  output  NUM_CH  per-channel beat accepted/valid
iresp_last  output  NUM_CH  per-channel final beat
iresp_data  output  NUM_CH*DATA_W  per-channel read data
oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len, oreq_burst  output  1/1/3/ADDR_W/DATA_W/8/DATA_W/LEN_W/2  forwarded request
oresp_ready  input  1  downstream beat handshake
oresp_last  input  1  downstream final beat
oresp_data  input  DATA_W  downstream read data
grant_valid  output  1  arbiter locked to a channel
grant_idx  output  $clog2(NUM_CH)  locked channel index

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, grant_valid=0, grant_idx=0, rr_ptr=0.
- While in reset all combinational outputs are 0: oreq_valid=0, iresp_ready=0, iresp_last=0.
- Reset mid-burst aborts the transaction; no response is routed afterwards.
- States: IDLE, BUSY.
- IDLE:
  - oreq_valid=0; all iresp_ready=0.
  - If any ireq_valid is set, select the winner, register grant_idx, set grant_valid=1, and go to BUSY next cycle.
  - Arbitration latency: exactly 1 cycle from request to oreq_valid.
- Round-robin winner: first valid channel scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_CH.
  - On grant, rr_ptr <= winner+1 (wrapping NUM_CH-1 -> 0).
- BUSY:
  - All oreq_* fields driven combinationally from channel grant_idx.
  - iresp_ready/last/data[grant_idx] = oresp_ready/last/data.
  - All other channels: ready=0, last=0, data=0.
- Release: at a cycle with oresp_ready && oresp_last, go to IDLE next cycle.
  - One mandatory idle bubble between transactions; no back-to-back grant.
- Requester rule: ireq fields stay stable from first valid until its last handshake.
  - If the granted channel deasserts valid while BUSY (protocol violation), oreq_valid follows it to 0 and the arbiter returns to IDLE next cycle.
- Non-granted channels asserting valid are ignored; their requests persist until granted.
- Single-beat transfer (len=0): last beat equals first beat, so the release rule still applies.
- No combinational path from oresp_* to oreq_*.

Optional Feature:
- CBUS_ARB_FIXED_PRIO_EN defined:
  - Winner is the lowest-index valid channel (channel 0 highest priority).
  - rr_ptr is removed.
  - Starvation of higher indices is accepted.
- Undefined: round-robin as above.

Test Plan:
1. Reset held low 3 cycles with ireq_valid=4'b1111 -> oreq_valid=0, grant_valid=0, all iresp_ready=0; after release, channel 0 is granted the cycle after first IDLE.
2. All 4 channels valid continuously, each len=0, oresp_ready=last=1 every BUSY cycle -> grant order 0,1,2,3,0; one IDLE cycle between each grant.
3. Channel 2 read burst, len=3, addr=0x80001000; oresp_ready pulsed on cycles 1,3,4,6 with last on the 4th beat -> channel 2 sees exactly 4 ready beats matching oresp_data; grant held throughout although channel 0 is valid.
4. Channel 1 granted, then drops valid after 1 beat of a 4-beat burst -> oreq_valid=0 same cycle; IDLE next cycle; re-arbitration proceeds.
5. Reset asserted mid-burst on beat 2 -> next cycle grant_valid=0, oreq_valid=0; no iresp_ready for the remaining beats.
6. With CBUS_ARB_FIXED_PRIO_EN, channels 3 and 1 both valid repeatedly -> channel 1 granted every time; channel 3 only once channel 1 is idle.
